execution_unit_v2: RTL and testbench

Parametrised successor to the current execution unit: a single-issue accumulator datapath with an N-entry register file, a multi-cycle barrel-free shifter, sticky status flags and a valid/ready instruction handshake. It sits between the SPI instruction front-end and the output pins. It accepts one 4-bit opcode per handshake and drives an ACC_WIDTH-bit result with a one-cycle `out_valid` strobe. The SPI front-end must back-pressure on `instr_ready` during shifts.

---
 rtl/execution_unit_v2.sv | 169 ++++++++++++++++
 tb/tb_execution_unit_v2.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execution_unit_v2.sv
// execution_unit_v2
// Single-issue accumulator datapath. It has an N-entry register file, a
// one-bit-per-cycle shift register, sticky status flags, a skip flag and a
// valid/ready instruction intake.
// Optional build macro: EU_SATURATE_EN makes ADD/SUB/ACS saturate instead of
// wrapping. The overflow flag is still set when a result clamps.
module execution_unit_v2 #(
   parameter int  DATA_WIDTH = 4,
   parameter int  ACC_WIDTH  = 8,
   parameter int  NUM_REGS   = 4,
   localparam int RSEL_W     = $clog2(NUM_REGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  instr_valid,
   output logic                  instr_ready,
   input  logic [3:0]            opcode,
   input  logic [RSEL_W-1:0]     reg_sel,
   input  logic [DATA_WIDTH-1:0] imm,
   output logic [ACC_WIDTH-1:0]  cpu_out,
   output logic                  out_valid,
   output logic                  zero,
   output logic                  overflow,
   output logic                  busy
);

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0, OP_LDR  = 4'h1, OP_LDO = 4'h2, OP_CLR = 4'h3,
      OP_ADD  = 4'h4, OP_SUB  = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
      OP_XOR  = 4'h8, OP_INV  = 4'h9, OP_LDS = 4'hA, OP_LSH = 4'hB,
      OP_RSH  = 4'hC, OP_ACS  = 4'hD, OP_SNZA = 4'hE, OP_SNZS = 4'hF
   } opcode_e;

   typedef enum logic {S_IDLE, S_SHIFT} state_e;

   state_e                state, state_nxt;
   opcode_e               op;
   logic                  ready_q;
   logic                  skip;
   logic                  shift_left;
   logic                  accept;
   logic                  start_shift;
   logic                  is_shift_op;
   logic [DATA_WIDTH-1:0] shift_cnt;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [ACC_WIDTH-1:0]  acc, sr, r_ext;
   logic [ACC_WIDTH-1:0]  add_res, sub_res, acs_res;
   logic [ACC_WIDTH:0]    add_sum, sub_diff, acs_sum;

   assign op          = opcode_e'(opcode);
   assign is_shift_op = (op == OP_LSH) || (op == OP_RSH);
   assign r_ext       = ACC_WIDTH'(regs[reg_sel]);
   assign zero        = (acc == '0);
   assign busy        = (state != S_IDLE);

   // One extra bit on each result holds the carry or borrow for the overflow flag.
   assign add_sum  = {1'b0, acc} + {1'b0, r_ext};
   assign acs_sum  = {1'b0, acc} + {1'b0, sr};
   assign sub_diff = {1'b0, acc} - {1'b0, r_ext};

`ifdef EU_SATURATE_EN
   assign add_res = add_sum[ACC_WIDTH]  ? '1 : add_sum[ACC_WIDTH-1:0];
   assign acs_res = acs_sum[ACC_WIDTH]  ? '1 : acs_sum[ACC_WIDTH-1:0];
   assign sub_res = sub_diff[ACC_WIDTH] ? '0 : sub_diff[ACC_WIDTH-1:0];
`else
   assign add_res = add_sum[ACC_WIDTH-1:0];
   assign acs_res = acs_sum[ACC_WIDTH-1:0];
   assign sub_res = sub_diff[ACC_WIDTH-1:0];
`endif

   // State register for the shift sequencer.
   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic, handshake and shift-start decode.
   always_comb begin
      // NOTE: every signal gets a default first, so no path through the block can infer a latch.
      state_nxt   = state;
      instr_ready = 1'b0;
      accept      = 1'b0;
      start_shift = 1'b0;
      case (state)
         S_IDLE: begin
            instr_ready = ready_q;
            accept      = instr_valid && ready_q;
            // A shift by 1 completes on the accepting edge. Only longer shifts occupy SHIFT.
            start_shift = accept && !skip && is_shift_op && (imm > DATA_WIDTH'(1));
            if (start_shift) state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            // The count reaches zero with the bit moved on this edge.
            if (shift_cnt == DATA_WIDTH'(1)) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Datapath: executes the accepted opcode, or advances an in-flight shift.
   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: the register file is cleared by reset because software relies on R[n]=0 after reset.
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         acc        <= '0;
         sr         <= '0;
         cpu_out    <= '0;
         out_valid  <= 1'b0;
         overflow   <= 1'b0;
         skip       <= 1'b0;
         shift_cnt  <= '0;
         shift_left <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every register sees pre-edge values of its peers.
         ready_q   <= 1'b1;
         out_valid <= 1'b0;
         if (state == S_SHIFT) begin
            sr        <= shift_left ? (sr << 1) : (sr >> 1);
            shift_cnt <= shift_cnt - 1'b1;
         end else if (accept) begin
            if (skip) begin
               skip <= 1'b0;
            end else begin
               case (op)
                  OP_LDR: regs[reg_sel] <= imm;
                  OP_LDO: begin
                     cpu_out   <= acc;
                     out_valid <= 1'b1;
                  end
                  OP_CLR: begin
                     acc      <= '0;
                     overflow <= 1'b0;
                  end
                  OP_ADD: begin
                     acc <= add_res;
                     if (add_sum[ACC_WIDTH]) overflow <= 1'b1;
                  end
                  OP_SUB: begin
                     acc <= sub_res;
                     if (sub_diff[ACC_WIDTH]) overflow <= 1'b1;
                  end
                  OP_AND: acc <= acc & r_ext;
                  OP_OR:  acc <= acc | r_ext;
                  OP_XOR: acc <= acc ^ r_ext;
                  OP_INV: acc <= ~acc;
                  OP_LDS: sr  <= r_ext;
                  OP_LSH, OP_RSH: begin
                     // The first bit moves on the accepting edge. The remainder runs in SHIFT.
                     if (imm != '0) begin
                        sr         <= (op == OP_LSH) ? (sr << 1) : (sr >> 1);
                        shift_left <= (op == OP_LSH);
                        shift_cnt  <= imm - 1'b1;
                     end
                  end
                  OP_ACS: begin
                     acc <= acs_res;
                     if (acs_sum[ACC_WIDTH]) overflow <= 1'b1;
                  end
                  OP_SNZA: if (acc == '0) skip <= 1'b1;
                  OP_SNZS: if (sr == '0)  skip <= 1'b1;
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_execution_unit_v2.sv
// Self-checking bench for execution_unit_v2. An instruction-level reference
// model tracks ACC, SR, registers, flags and the number of busy cycles left.
// One process compares every DUT output with the model on each falling edge.
// Directed sequences add literal expectations, followed by a randomized run.
module tb_execution_unit_v2;
   localparam int DW   = 4;
   localparam int AW   = 8;
   localparam int NR   = 4;
   localparam int RW   = 2;
   localparam int MAXV = (1 << AW) - 1;

   localparam int NOP = 0, LDR = 1, LDO = 2, CLR = 3, ADD = 4, SUB = 5,
                  ANDO = 6, ORO = 7, XORO = 8, INV = 9, LDS = 10, LSH = 11,
                  RSH = 12, ACS = 13, SNZA = 14, SNZS = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          instr_valid = 1'b0;
   logic [3:0]    opcode = '0;
   logic [RW-1:0] reg_sel = '0;
   logic [DW-1:0] imm = '0;
   logic          instr_ready, out_valid, zero, overflow, busy;
   logic [AW-1:0] cpu_out;

   execution_unit_v2 #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_REGS(NR)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .opcode(opcode), .reg_sel(reg_sel), .imm(imm), .cpu_out(cpu_out),
      .out_valid(out_valid), .zero(zero), .overflow(overflow), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference model state.
   int m_acc, m_sr, m_out, m_rem;
   int m_regs[NR];
   bit m_ovf, m_ovv, m_skip, m_rdy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Apply one rising edge to the model at the instruction level. A shift
   // updates SR immediately and leaves imm-1 cycles of occupancy.
   task automatic model_edge(input bit rst_n, input bit v, input int op, input int rs, input int im);
      bit acc_ok;
      int t;
      if (!rst_n) begin
         m_acc = 0; m_sr = 0; m_out = 0; m_rem = 0;
         m_ovf = 0; m_ovv = 0; m_skip = 0; m_rdy = 0;
         foreach (m_regs[i]) m_regs[i] = 0;
         return;
      end
      m_ovv  = 0;
      acc_ok = v && m_rdy && (m_rem == 0);
      if (m_rem > 0) m_rem--;
      m_rdy = 1;
      if (!acc_ok) return;
      if (m_skip) begin
         m_skip = 0;
         return;
      end
      case (op)
         LDR:  m_regs[rs] = im;
         LDO:  begin m_out = m_acc; m_ovv = 1; end
         CLR:  begin m_acc = 0; m_ovf = 0; end
         ADD, ACS: begin
            t = m_acc + ((op == ADD) ? m_regs[rs] : m_sr);
            if (t > MAXV) begin
               m_ovf = 1;
`ifdef EU_SATURATE_EN
               t = MAXV;
`else
               t = t - (MAXV + 1);
`endif
            end
            m_acc = t;
         end
         SUB: begin
            t = m_acc - m_regs[rs];
            if (t < 0) begin
               m_ovf = 1;
`ifdef EU_SATURATE_EN
               t = 0;
`else
               t = t + MAXV + 1;
`endif
            end
            m_acc = t;
         end
         ANDO: m_acc = m_acc & m_regs[rs];
         ORO:  m_acc = m_acc | m_regs[rs];
         XORO: m_acc = m_acc ^ m_regs[rs];
         INV:  m_acc = (~m_acc) & MAXV;
         LDS:  m_sr = m_regs[rs];
         LSH, RSH: begin
            if (im >= AW)       m_sr = 0;
            else if (op == LSH) m_sr = (m_sr << im) & MAXV;
            else                m_sr = m_sr >> im;
            if (im > 0) m_rem = im - 1;
         end
         SNZA: if (m_acc == 0) m_skip = 1;
         SNZS: if (m_sr == 0)  m_skip = 1;
         default: ;
      endcase
   endtask

   // Drive one cycle, then advance the model on the same rising edge.
   task automatic cyc(input bit rst_n, input bit v, input int op, input int rs, input int im);
      reset       = rst_n;
      instr_valid = v;
      opcode      = op[3:0];
      reg_sel     = rs[RW-1:0];
      imm         = im[DW-1:0];
      @(posedge clk);
      model_edge(rst_n, v, op, rs, im);
      #1;
   endtask

   task automatic idle();
      cyc(1, 0, NOP, 0, 0);
   endtask

   // Present an instruction and hold it until the unit accepts it (bounded).
   task automatic issue(input int op, input int rs, input int im);
      bit taken;
      for (int n = 0; n < 40; n++) begin
         taken = instr_ready;
         cyc(1, 1, op, rs, im);
         if (taken) return;
      end
      check("issue_timeout", 32'd0, 32'd1);
   endtask

   // Compare every DUT output with the model on each falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("instr_ready", instr_ready, m_rdy && (m_rem == 0));
         check("busy",        busy,        m_rem > 0);
         check("cpu_out",     cpu_out,     m_out);
         check("out_valid",   out_valid,   m_ovv);
         check("zero",        zero,        m_acc == 0);
         check("overflow",    overflow,    m_ovf);
      end
   end

   initial begin
      int lows;
      int op, rs, im;

      // Reset held for three cycles, then released.
      cyc(0, 0, NOP, 0, 0);
      chk_en = 1'b1;
      cyc(0, 0, NOP, 0, 0);
      cyc(0, 1, LDR, 0, 5);
      check("rst_ready", instr_ready, 32'd0);
      check("rst_cpu_out", cpu_out, 32'd0);
      check("rst_overflow", overflow, 32'd0);
      check("rst_zero", zero, 32'd1);
      idle();
      check("ready_after_release", instr_ready, 32'd1);

      // 17 x 15 = 255 fits in 8 bits. The 18th ADD carries out.
      issue(LDR, 0, 4'hF);
      for (int i = 0; i < 17; i++) issue(ADD, 0, 0);
      issue(LDO, 0, 0);
      check("ldo17_cpu_out", cpu_out, 32'hFF);
      check("ldo17_out_valid", out_valid, 32'd1);
      check("ldo17_overflow", overflow, 32'd0);
      issue(ADD, 0, 0);
      issue(LDO, 0, 0);
      check("add18_overflow", overflow, 32'd1);
`ifdef EU_SATURATE_EN
      check("add18_cpu_out", cpu_out, 32'hFF);
`else
      check("add18_cpu_out", cpu_out, 32'h0E);
`endif
      idle();
      check("out_valid_drops", out_valid, 32'd0);

      // Left shift by 3: ready is low for exactly two cycles after the accept.
      issue(CLR, 0, 0);
      check("clr_zero", zero, 32'd1);
      issue(LDR, 1, 4'h9);
      issue(LDS, 1, 0);
      issue(LSH, 0, 3);
      lows = 0;
      for (int i = 0; i < 10 && !instr_ready; i++) begin
         lows++;
         idle();
      end
      check("lsh3_ready_low_cycles", lows, 32'd2);
      issue(ACS, 0, 0);
      issue(LDO, 0, 0);
      check("lsh3_cpu_out", cpu_out, 32'h48);

      // A right shift by 2, and a shift by at least ACC_WIDTH, which clears SR.
      issue(CLR, 0, 0);
      issue(LDR, 1, 4'hC);
      issue(LDS, 1, 0);
      issue(RSH, 0, 2);
      issue(ACS, 0, 0);
      issue(LDS, 1, 0);
      issue(LSH, 0, 9);
      issue(ACS, 0, 0);
      issue(LDO, 0, 0);
      check("rsh2_lsh9_cpu_out", cpu_out, 32'h03);

      // SUB borrow wraps and sets overflow.
      issue(CLR, 0, 0);
      issue(LDR, 0, 1);
      issue(SUB, 0, 0);
      issue(LDO, 0, 0);
      check("sub_borrow_overflow", overflow, 32'd1);
`ifdef EU_SATURATE_EN
      check("sub_borrow_cpu_out", cpu_out, 32'h00);
`else
      check("sub_borrow_cpu_out", cpu_out, 32'hFF);
`endif

      // SNZA on ACC==0 discards the first ADD.
      issue(LDR, 0, 5);
      issue(CLR, 0, 0);
      issue(SNZA, 0, 0);
      issue(ADD, 0, 0);
      issue(ADD, 0, 0);
      issue(LDO, 0, 0);
      check("snza_cpu_out", cpu_out, 32'h05);

      // A skipped LSH takes a single cycle and never drops ready.
      issue(LDR, 2, 0);
      issue(LDS, 2, 0);
      issue(SNZS, 0, 0);
      issue(LSH, 0, 4);
      check("skipped_lsh_ready", instr_ready, 32'd1);
      check("skipped_lsh_busy", busy, 32'd0);
      issue(NOP, 0, 0);

      // Reset during a 6-cycle shift aborts it and clears SR.
      issue(LDR, 3, 1);
      issue(LDS, 3, 0);
      issue(LSH, 0, 6);
      idle();
      check("midshift_busy", busy, 32'd1);
      idle();
      cyc(0, 0, NOP, 0, 0);
      check("midshift_reset_busy", busy, 32'd0);
      idle();
      issue(LDR, 0, 5);
      issue(ADD, 0, 0);
      issue(ACS, 0, 0);
      issue(LDO, 0, 0);
      check("midshift_sr_cleared", cpu_out, 32'h05);

      // Randomized traffic: random opcodes and operands, with idle gaps and rare resets.
      for (int n = 0; n < 3000; n++) begin
         op = $urandom_range(0, 15);
         rs = $urandom_range(0, NR - 1);
         im = $urandom_range(0, (1 << DW) - 1);
         if ($urandom_range(0, 399) == 0) begin
            cyc(0, $urandom_range(0, 1), op, rs, im);
         end else if ($urandom_range(0, 3) == 0) begin
            cyc(1, 0, op, rs, im);
         end else begin
            issue(op, rs, im);
         end
      end
      idle();
      idle();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
